// File: rtl/multi_freq_counter.sv
// multi_freq_counter: N-channel reciprocal frequency counter with a shared round-robin restoring divider.
module multi_freq_counter #(
  parameter int N_CH        = 4,
  parameter int M_EDGES     = 50,
  parameter int F_CLK       = 40000,
  parameter int F_W         = 14,
  parameter int CNT_W       = 24,
  parameter int TIMEOUT_CYC = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [N_CH-1:0]     sig,
  input  logic [N_CH-1:0]     ch_en,
  output logic [N_CH*F_W-1:0] f,
  output logic [N_CH-1:0]     f_valid,
  output logic [N_CH-1:0]     ovf,
  output logic [N_CH-1:0]     stale
);
  localparam int NUM_W = $clog2(M_EDGES*F_CLK+1);
  localparam int E_W   = $clog2(M_EDGES+1);
  localparam int CH_W  = N_CH > 1 ? $clog2(N_CH) : 1;
  localparam int C_W   = $clog2(NUM_W+1);
  localparam int F_MAX = (1 << F_W) - 1;
  localparam logic [NUM_W-1:0] NUM = NUM_W'(M_EDGES*F_CLK);
  typedef enum logic {IDLE, MEAS} state_t;
  logic [N_CH-1:0]  r_s1, r_s2, r_s3, r_edge, r_req;
  state_t           r_st  [N_CH];
  logic [CNT_W-1:0] r_n   [N_CH];
  logic [E_W-1:0]   r_e   [N_CH];
  logic [CNT_W-1:0] r_den [N_CH];
  logic [F_W-1:0]   r_f   [N_CH];
  logic             r_busy;
  logic [C_W-1:0]   r_cnt;
  logic [CH_W-1:0]  r_ch, r_ptr;
  logic [CNT_W-1:0] r_dv, r_rem;
  logic [NUM_W-1:0] r_quo;
  logic [N_CH-1:0]  w_rq;
  logic [CH_W-1:0]  w_g, w_idx;
  logic             w_gv, w_grant, w_ge, w_sat;
  logic [CNT_W:0]   w_sh;
  assign w_rq    = r_req & ch_en;
  assign w_grant = w_gv & ~r_busy;
  assign w_sh    = {r_rem, r_quo[NUM_W-1]};
  assign w_ge    = w_sh >= {1'b0, r_dv};
  assign w_sat   = (r_dv == '0) || ((NUM_W+F_W)'(r_quo) > (NUM_W+F_W)'(F_MAX));
  for (genvar j = 0; j < N_CH; j++) assign f[j*F_W +: F_W] = r_f[j];
  // Descending scan so the first requester at or after r_ptr wins.
  always_comb begin
    w_gv  = 1'b0;
    w_g   = '0;
    w_idx = '0;
    for (int k = N_CH-1; k >= 0; k--) begin
      w_idx = CH_W'((int'(r_ptr) + k) % N_CH);
      w_gv  = w_rq[w_idx] ? 1'b1 : w_gv;
      w_g   = w_rq[w_idx] ? w_idx : w_g;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= '0;
      r_s2 <= '0;
      r_s3 <= '0;
      r_edge <= '0;
      r_req <= '0;
      r_busy <= 1'b0;
      r_cnt <= '0;
      r_ch <= '0;
      r_ptr <= '0;
      r_dv <= '0;
      r_rem <= '0;
      r_quo <= '0;
      f_valid <= '0;
      ovf <= '0;
      stale <= '0;
      for (int i = 0; i < N_CH; i++) begin
        r_st[i] <= IDLE;
        r_n[i] <= '0;
        r_e[i] <= '0;
        r_den[i] <= '0;
        r_f[i] <= '0;
      end
    end else begin
      r_s1 <= sig;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
      r_edge <= r_s2 & ~r_s3;
      f_valid <= '0;
      if (w_grant) begin
        r_busy <= 1'b1;
        r_cnt <= '0;
        r_rem <= '0;
        r_quo <= NUM;
        r_dv <= r_den[w_g];
        r_ch <= w_g;
        r_req[w_g] <= 1'b0;
        r_ptr <= (w_g == CH_W'(N_CH-1)) ? '0 : w_g + 1'b1;
      end else if (r_busy && r_cnt != C_W'(NUM_W)) begin
        r_cnt <= r_cnt + 1'b1;
        r_rem <= CNT_W'(w_ge ? w_sh - {1'b0, r_dv} : w_sh);
        r_quo <= {r_quo[NUM_W-2:0], w_ge};
      end else if (r_busy) begin
        r_busy <= 1'b0;
        r_f[r_ch] <= w_sat ? F_W'(F_MAX) : r_quo[F_W-1:0];
        ovf[r_ch] <= w_sat;
        stale[r_ch] <= 1'b0;
        f_valid[r_ch] <= 1'b1;
      end
      // Channel updates come last so a timeout overrides a same-cycle write-back.
      for (int i = 0; i < N_CH; i++) begin
        if (!ch_en[i]) begin
          r_st[i] <= IDLE;
          r_n[i] <= '0;
          r_e[i] <= '0;
          r_req[i] <= 1'b0;
        end else if (r_st[i] == IDLE) begin
          r_n[i] <= CNT_W'(r_edge[i]);
          r_e[i] <= '0;
          r_st[i] <= r_edge[i] ? MEAS : IDLE;
        end else if (r_edge[i] && r_e[i] == E_W'(M_EDGES-1)) begin
          r_req[i] <= 1'b1;
          r_den[i] <= r_n[i];
          r_n[i] <= CNT_W'(1);
          r_e[i] <= '0;
        end else if (r_edge[i]) begin
          r_n[i] <= r_n[i] + 1'b1;
          r_e[i] <= r_e[i] + 1'b1;
        end else if (r_n[i] >= CNT_W'(TIMEOUT_CYC)) begin
          r_st[i] <= IDLE;
          r_n[i] <= '0;
          r_e[i] <= '0;
          r_f[i] <= '0;
          stale[i] <= 1'b1;
          ovf[i] <= 1'b0;
          f_valid[i] <= 1'b1;
        end else begin
          r_n[i] <= r_n[i] + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_multi_freq_counter.sv
// tb_multi_freq_counter: directed scenarios for the multi-channel reciprocal frequency counter.
module tb_multi_freq_counter;
  localparam int N = 4, FW = 14, TO = 6000;
  logic clk = 1'b0, rst = 1'b1;
  logic [N-1:0] sig = '0, ch_en = '0, man = '0;
  logic [N*FW-1:0] f;
  logic [N-1:0] f_valid, ovf, stale;
  int per[N] = '{1, 1, 1, 1};
  int st[N];
  bit gen[N];
  int cyc, n_chk, n_fail;
  int lg_ch[$], lg_cyc[$], lg_f[$];
  bit lg_ovf[$], lg_st[$];

  multi_freq_counter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .sig(sig), .ch_en(ch_en),
    .f(f), .f_valid(f_valid), .ovf(ovf), .stale(stale)
  );

  always #5 clk = ~clk;

  function automatic int fget(int i);
    return int'(f[i*FW +: FW]);
  endfunction

  task automatic tick();
    @(negedge clk);
    cyc++;
    for (int i = 0; i < N; i++) begin
      if (f_valid[i]) begin
        lg_ch.push_back(i); lg_cyc.push_back(cyc); lg_f.push_back(fget(i));
        lg_ovf.push_back(ovf[i]); lg_st.push_back(stale[i]);
      end
      sig[i] = (gen[i] && cyc >= st[i]) ? (((cyc - st[i]) % per[i]) < (per[i] + 1) / 2) : man[i];
    end
  endtask

  task automatic restart();
    gen = '{default: 0};
    man = '0;
    rst = 1'b1;
    repeat (3) tick();
    rst = 1'b0;
    lg_ch.delete(); lg_cyc.delete(); lg_f.delete(); lg_ovf.delete(); lg_st.delete();
  endtask

  task automatic wait_log(int n, int budget, string nm);
    int b = 0;
    while (lg_ch.size() < n && b < budget) begin tick(); b++; end
    n_chk++; if (lg_ch.size() < n) begin n_fail++; $display("FAIL %s_wait: got %0d strobes, required %0d", nm, lg_ch.size(), n); end
  endtask

  task automatic test_reset();
    rst = 1'b1; ch_en = '1;
    repeat (3) tick();
    n_chk++; if (f !== '0) begin n_fail++; $display("FAIL reset_f: got %h required 0", f); end
    n_chk++; if (f_valid !== '0) begin n_fail++; $display("FAIL reset_f_valid: got %b required 0", f_valid); end
    n_chk++; if (ovf !== '0) begin n_fail++; $display("FAIL reset_ovf: got %b required 0", ovf); end
    n_chk++; if (stale !== '0) begin n_fail++; $display("FAIL reset_stale: got %b required 0", stale); end
  endtask

  task automatic test_single(int p, int ef, bit eo, string nm);
    restart();
    ch_en = 4'b0001; per[0] = p; st[0] = cyc + 1; gen[0] = 1;
    wait_log(3, 160*p + 100, nm);
    for (int k = 0; k < 3; k++) if (k < lg_ch.size()) begin
      n_chk++; if (lg_ch[k] !== 0) begin n_fail++; $display("FAIL %s_ch[%0d]: got %0d required 0", nm, k, lg_ch[k]); end
      n_chk++; if (lg_f[k] !== ef) begin n_fail++; $display("FAIL %s_f[%0d]: got %0d required %0d", nm, k, lg_f[k], ef); end
      n_chk++; if (lg_ovf[k] !== eo) begin n_fail++; $display("FAIL %s_ovf[%0d]: got %0d required %0d", nm, k, lg_ovf[k], eo); end
      n_chk++; if (lg_st[k] !== 1'b0) begin n_fail++; $display("FAIL %s_stale[%0d]: got %0d required 0", nm, k, lg_st[k]); end
      if (k > 0) begin
        n_chk++; if (lg_cyc[k] - lg_cyc[k-1] !== 50*p) begin n_fail++; $display("FAIL %s_gap[%0d]: got %0d required %0d", nm, k, lg_cyc[k] - lg_cyc[k-1], 50*p); end
      end
    end
  endtask

  task automatic test_back_to_back();
    int ef[N] = '{4000, 1739, 800, 400};
    int base;
    restart();
    ch_en = '1; per = '{10, 23, 50, 100};
    base = cyc + 10;
    for (int i = 0; i < N; i++) begin st[i] = base + 5000 - 50*per[i]; gen[i] = 1; end
    wait_log(4, 5200, "b2b");
    for (int k = 0; k < N; k++) if (k < lg_ch.size()) begin
      n_chk++; if (lg_ch[k] !== k) begin n_fail++; $display("FAIL b2b_order[%0d]: got ch %0d required %0d", k, lg_ch[k], k); end
      n_chk++; if (lg_f[k] !== ef[k]) begin n_fail++; $display("FAIL b2b_f[%0d]: got %0d required %0d", k, lg_f[k], ef[k]); end
      n_chk++; if (lg_ovf[k] !== 1'b0) begin n_fail++; $display("FAIL b2b_ovf[%0d]: got %0d required 0", k, lg_ovf[k]); end
      if (k > 0) begin
        n_chk++; if (lg_cyc[k] - lg_cyc[k-1] !== 23) begin n_fail++; $display("FAIL b2b_gap[%0d]: got %0d required 23", k, lg_cyc[k] - lg_cyc[k-1]); end
      end
    end
  endtask

  task automatic test_timeout();
    restart();
    ch_en = 4'b0001; man[0] = 1'b1;
    repeat (4) tick();
    man[0] = 1'b0;
    wait_log(1, TO + 100, "timeout");
    if (lg_ch.size() > 0) begin
      n_chk++; if (lg_f[0] !== 0) begin n_fail++; $display("FAIL timeout_f: got %0d required 0", lg_f[0]); end
      n_chk++; if (lg_st[0] !== 1'b1) begin n_fail++; $display("FAIL timeout_stale: got %0d required 1", lg_st[0]); end
      n_chk++; if (lg_ovf[0] !== 1'b0) begin n_fail++; $display("FAIL timeout_ovf: got %0d required 0", lg_ovf[0]); end
    end
    repeat (50) tick();
    n_chk++; if (lg_ch.size() !== 1) begin n_fail++; $display("FAIL timeout_count: got %0d strobes required 1", lg_ch.size()); end
    n_chk++; if (stale[0] !== 1'b1) begin n_fail++; $display("FAIL timeout_stale_out: got %0d required 1", stale[0]); end
    per[0] = 10; st[0] = cyc + 1; gen[0] = 1;
    wait_log(2, 700, "resume");
    if (lg_ch.size() > 1) begin
      n_chk++; if (lg_f[1] !== 4000) begin n_fail++; $display("FAIL resume_f: got %0d required 4000", lg_f[1]); end
      n_chk++; if (lg_st[1] !== 1'b0) begin n_fail++; $display("FAIL resume_stale: got %0d required 0", lg_st[1]); end
    end
  endtask

  task automatic test_rst_mid();
    restart();
    ch_en = 4'b0001; per[0] = 10; st[0] = cyc + 1; gen[0] = 1;
    wait_log(1, 700, "rstmid_pre");
    n_chk++; if (fget(0) !== 4000) begin n_fail++; $display("FAIL rstmid_pre_f: got %0d required 4000", fget(0)); end
    repeat (488) tick();
    rst = 1'b1;
    tick();
    n_chk++; if (f !== '0) begin n_fail++; $display("FAIL rstmid_f: got %h required 0", f); end
    n_chk++; if ({f_valid, ovf, stale} !== '0) begin n_fail++; $display("FAIL rstmid_flags: got %b required 0", {f_valid, ovf, stale}); end
    repeat (2) tick();
    rst = 1'b0; gen[0] = 0;
    repeat (40) tick();
    n_chk++; if (lg_ch.size() !== 1) begin n_fail++; $display("FAIL rstmid_strobe: got %0d strobes required 1", lg_ch.size()); end
  endtask

  task automatic test_ch_en_drop();
    restart();
    ch_en = '1; per[1] = 10; st[1] = cyc + 1; gen[1] = 1;
    wait_log(1, 700, "drop_pre");
    n_chk++; if (fget(1) !== 4000) begin n_fail++; $display("FAIL drop_pre_f: got %0d required 4000", fget(1)); end
    repeat (200) tick();
    ch_en[1] = 1'b0;
    repeat (800) tick();
    n_chk++; if (lg_ch.size() !== 1) begin n_fail++; $display("FAIL drop_strobe: got %0d strobes required 1", lg_ch.size()); end
    n_chk++; if (fget(1) !== 4000) begin n_fail++; $display("FAIL drop_hold_f: got %0d required 4000", fget(1)); end
    n_chk++; if ({ovf[1], stale[1]} !== 2'b00) begin n_fail++; $display("FAIL drop_hold_flags: got %b required 00", {ovf[1], stale[1]}); end
  endtask

  initial begin
    test_reset();
    test_single(10, 4000, 1'b0, "p10");
    test_single(100, 400, 1'b0, "p100");
    test_single(23, 1739, 1'b0, "p23");
    test_single(50, 800, 1'b0, "p50");
    test_single(2, 16383, 1'b1, "sat");
    test_back_to_back();
    test_timeout();
    test_rst_mid();
    test_ch_en_drop();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
